// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect with
// mid-bit glitch rejection, mid-bit data sampling, valid/ready byte output.
module uart_rx #(
  parameter int BAUD = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CW = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] HALF_C = CW'(BAUD / 2);
  localparam logic [CW-1:0] LAST_C = CW'(BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          sync1, rx_s, rx_d;
  logic [2:0]    fill;

  // fill marks when rx_s and rx_d both hold real line samples, so the
  // reset value of the synchroniser can never fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      fill  <= 3'b000;
    end else begin
      sync1 <= i_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
      fill  <= {fill[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fill[2] && rx_d && !rx_s) begin
            state  <= START;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        // START is entered two edges after the first low sample, so the
        // check at cnt==HALF lands 3+BAUD/2 edges after that sample.
        START: begin
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST_C) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= '0;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST_C) begin
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
            if (rx_s) begin
              o_data    <= shift;
              o_valid   <= 1'b1;
              o_overrun <= o_valid && !i_ready;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
